// File: rtl/fbc_seq_pkg.sv
// Shared encodings and constants for the FBC loop sequencer.
// State and mode values are visible on state_o / mode_o, so they must stay fixed.
package fbc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_UFEED = 3'd1,
    ST_WAIT_PID   = 3'd2,
    ST_DAC_WR     = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BIAS   = 2'd1,
    MODE_CALI   = 2'd2,
    MODE_CLOSED = 2'd3
  } mode_e;

  localparam int unsigned MIN_PERIOD_DEF = 63;
  localparam logic [15:0] CNT_SAT        = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fbc_period_tick.sv
// Free-running period counter; emits a registered one-cycle tick each period.
// Periods shorter than MIN_PERIOD are clamped so the loop cannot be overdriven.
module fbc_period_tick
  import fbc_seq_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  logic [31:0] cnt_q, cnt_d, limit;
  logic        tick_q, tick_d;

  // period_i is read live, so a new value applies at the next compare
  always_comb begin
    limit  = (period_i < MIN_P) ? MIN_P : period_i;
    tick_d = (cnt_q >= limit);
    cnt_d  = tick_d ? '0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/fbc_loop_sequencer.sv
// One FBC control iteration per tick: Ufeed read, PID start/capture, DAC write.
// Chooses calibration, bias or PID data each period and keeps timeout/overrun stats.
module fbc_loop_sequencer
  import fbc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned SETTLE_TRIG = 16,
  parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        loop_en_i,
  input  logic        cali_en_i,
  input  logic [31:0] period_i,
  input  logic [15:0] bias_voltage_i,
  input  logic [15:0] cali_uop_i,
  output logic        ufeed_rd_o,
  input  logic        ufeed_vld_i,
  output logic        pid_start_o,
  input  logic        pid_done_i,
  input  logic [15:0] pid_data_i,
  output logic        dac_wr_o,
  output logic [15:0] dac_data_o,
  input  logic        dac_ready_i,
  output logic [2:0]  state_o,
  output logic [1:0]  mode_o,
  output logic [15:0] timeout_cnt_o,
  output logic [15:0] overrun_cnt_o
);

  localparam int unsigned SW = $clog2(SETTLE_TRIG + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_TRIG);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYC - 1);

  logic          tick;
  state_e        state_q;
  mode_e         mode_d, mode_q;
  logic [SW-1:0] settle_q;
  logic [WW-1:0] wait_q;
  logic          ufeed_rd_q, pid_start_q, dac_wr_q;
  logic [15:0]   dac_data_q, timeout_q, overrun_q;

  fbc_period_tick #(.MIN_PERIOD(MIN_PERIOD)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  always_comb begin
    mode_d = MODE_OFF;
    if (cali_en_i)                            mode_d = MODE_CALI;
    else if (loop_en_i && settle_q < SETTLE_MAX) mode_d = MODE_BIAS;
    else if (loop_en_i)                       mode_d = MODE_CLOSED;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      settle_q    <= '0;
      wait_q      <= '0;
      ufeed_rd_q  <= 1'b0;
      pid_start_q <= 1'b0;
      dac_wr_q    <= 1'b0;
      dac_data_q  <= '0;
      timeout_q   <= '0;
      overrun_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      ufeed_rd_q  <= 1'b0;
      pid_start_q <= 1'b0;

      if (!loop_en_i || cali_en_i)
        settle_q <= '0;
      else if (tick && state_q == ST_IDLE && mode_d == MODE_BIAS)
        settle_q <= settle_q + 1'b1;

      // iterations are never queued: a busy tick is just counted
      if (tick && state_q != ST_IDLE)
        overrun_q <= sat_inc(overrun_q);

      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            case (mode_d)
              MODE_CALI, MODE_BIAS: begin
                state_q    <= ST_DAC_WR;
                dac_wr_q   <= 1'b1;
                dac_data_q <= (mode_d == MODE_CALI) ? cali_uop_i : bias_voltage_i;
              end
              MODE_CLOSED: begin
                state_q    <= ST_WAIT_UFEED;
                ufeed_rd_q <= 1'b1;
                wait_q     <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_WAIT_UFEED: begin
          wait_q <= wait_q + 1'b1;
          if (mode_d != MODE_CLOSED) begin
            state_q <= ST_IDLE;
          end else if (ufeed_vld_i) begin
            state_q     <= ST_WAIT_PID;
            pid_start_q <= 1'b1;
            wait_q      <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= ST_IDLE;
            timeout_q <= sat_inc(timeout_q);
          end
        end
        ST_WAIT_PID: begin
          wait_q <= wait_q + 1'b1;
          if (mode_d != MODE_CLOSED) begin
            state_q <= ST_IDLE;
          end else if (pid_done_i) begin
            state_q    <= ST_DAC_WR;
            dac_wr_q   <= 1'b1;
            dac_data_q <= pid_data_i;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= ST_IDLE;
            timeout_q <= sat_inc(timeout_q);
          end
        end
        ST_DAC_WR: begin
          if (dac_ready_i) begin
            state_q  <= ST_IDLE;
            dac_wr_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ufeed_rd_o    = ufeed_rd_q;
  assign pid_start_o   = pid_start_q;
  assign dac_wr_o      = dac_wr_q;
  assign dac_data_o    = dac_data_q;
  assign state_o       = state_q;
  assign mode_o        = mode_q;
  assign timeout_cnt_o = timeout_q;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_fbc_loop_sequencer.sv
// Randomized bench for fbc_loop_sequencer against a transaction-level reference model.
module tb_fbc_loop_sequencer;

  localparam int TMO    = 64;
  localparam int SETTLE = 16;
  localparam int MINP   = 63;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, loop_en_i = 1'b0, cali_en_i = 1'b0;
  logic [31:0] period_i = 32'd99;
  logic [15:0] bias_voltage_i = 16'h0A5A, cali_uop_i = 16'h8000, pid_data_i = 16'h1234;
  logic        ufeed_vld_i = 1'b0, pid_done_i = 1'b0, dac_ready_i = 1'b1;
  logic        ufeed_rd_o, pid_start_o, dac_wr_o;
  logic [15:0] dac_data_o, timeout_cnt_o, overrun_cnt_o;
  logic [2:0]  state_o;
  logic [1:0]  mode_o;

  always #5 clk = ~clk;

  fbc_loop_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .loop_en_i(loop_en_i), .cali_en_i(cali_en_i),
    .period_i(period_i), .bias_voltage_i(bias_voltage_i), .cali_uop_i(cali_uop_i),
    .ufeed_rd_o(ufeed_rd_o), .ufeed_vld_i(ufeed_vld_i), .pid_start_o(pid_start_o),
    .pid_done_i(pid_done_i), .pid_data_i(pid_data_i), .dac_wr_o(dac_wr_o),
    .dac_data_o(dac_data_o), .dac_ready_i(dac_ready_i), .state_o(state_o),
    .mode_o(mode_o), .timeout_cnt_o(timeout_cnt_o), .overrun_cnt_o(overrun_cnt_o)
  );

  int nvec = 0, nerr = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one iteration is a stage number plus the cycle it started waiting
  longint      m_elapsed = 0;
  bit          m_tick = 0, m_rd = 0, m_start = 0, m_wr = 0;
  int          m_settle = 0, m_stage = 0, m_entered = 0, m_mode = 0;
  logic [15:0] m_data = '0, m_tmo = '0, m_ovr = '0;

  function automatic logic [15:0] bump(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic int mode_now();
    if (cali_en_i) return 2;
    if (loop_en_i && m_settle < SETTLE) return 1;
    if (loop_en_i) return 3;
    return 0;
  endfunction

  task automatic model_step();
    int md;
    longint lim;
    bit t;
    cyc++;
    if (rst_i) begin
      m_elapsed = 0; m_tick = 0; m_rd = 0; m_start = 0; m_wr = 0;
      m_settle = 0; m_stage = 0; m_mode = 0; m_data = '0; m_tmo = '0; m_ovr = '0;
      return;
    end
    md  = mode_now();
    lim = (period_i < MINP) ? MINP : longint'(period_i);
    t   = m_tick;
    m_tick    = (m_elapsed >= lim);
    m_elapsed = m_tick ? 0 : m_elapsed + 1;
    if (!loop_en_i || cali_en_i) m_settle = 0;
    else if (t && m_stage == 0 && md == 1) m_settle++;
    if (t && m_stage != 0) m_ovr = bump(m_ovr);
    m_mode = md; m_rd = 0; m_start = 0;
    case (m_stage)
      0: if (t) begin
        if (md == 1 || md == 2) begin
          m_stage = 3; m_wr = 1; m_data = (md == 2) ? cali_uop_i : bias_voltage_i;
        end else if (md == 3) begin
          m_stage = 1; m_rd = 1; m_entered = cyc;
        end
      end
      1: if (md != 3) m_stage = 0;
         else if (ufeed_vld_i) begin m_stage = 2; m_start = 1; m_entered = cyc; end
         else if (cyc - m_entered == TMO) begin m_stage = 0; m_tmo = bump(m_tmo); end
      2: if (md != 3) m_stage = 0;
         else if (pid_done_i) begin m_stage = 3; m_wr = 1; m_data = pid_data_i; end
         else if (cyc - m_entered == TMO) begin m_stage = 0; m_tmo = bump(m_tmo); end
      3: if (dac_ready_i) begin m_stage = 0; m_wr = 0; end
      default: m_stage = 0;
    endcase
  endtask

  bit resp_u = 1, resp_p = 1, stray = 0;
  int rdy_pct = 100, nbias = 0;
  bit count_bias = 0;

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ctl", {state_o, mode_o, ufeed_rd_o, pid_start_o, dac_wr_o},
               {3'(m_stage), 2'(m_mode), m_rd, m_start, m_wr});
    chk("dac_data", dac_data_o, m_data);
    chk("stats", {timeout_cnt_o, overrun_cnt_o}, {m_tmo, m_ovr});
    if (count_bias && dac_wr_o && dac_ready_i && dac_data_o == bias_voltage_i) nbias++;
    ufeed_vld_i = (m_stage == 1 && resp_u && $urandom_range(0, 3) == 0) ||
                  (stray && $urandom_range(0, 15) == 0);
    pid_done_i  = (m_stage == 2 && resp_p && $urandom_range(0, 3) == 0) ||
                  (stray && $urandom_range(0, 15) == 0);
    pid_data_i  = 16'($urandom);
    dac_ready_i = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic run(input int n);
    repeat (n) if (nerr <= 40) cycle();
  endtask

  initial begin
    int got;
    logic [31:0] plist [4];
    plist[0] = 32'd10; plist[1] = 32'd63; plist[2] = 32'd64; plist[3] = 32'd80;

    run(3);
    rst_i = 1'b0;
    chk("reset_state", {state_o, mode_o, dac_wr_o, dac_data_o}, '0);

    // bias settle then closed loop at period 100
    loop_en_i = 1'b1; count_bias = 1;
    run(2600);
    count_bias = 0;
    chk("bias_writes", nbias, SETTLE);

    // calibration overrides the loop
    cali_en_i = 1'b1;
    run(600);
    cali_en_i = 1'b0;
    run(1700);

    // PID never answers: timeouts
    resp_p = 0;
    run(400);
    resp_p = 1;

    // DAC stalled across two ticks
    rdy_pct = 0;
    run(250);
    rdy_pct = 100;
    run(300);

    // short period clamps to 64 cycles
    period_i = 32'd10;
    run(400);

    // random mix: toggles, cali, period changes, stray pulses, back-pressure
    stray = 1;
    for (int k = 0; k < 20; k++) begin
      loop_en_i = ($urandom_range(0, 99) < 80);
      cali_en_i = ($urandom_range(0, 99) < 15);
      period_i  = plist[$urandom_range(0, 3)];
      rdy_pct   = $urandom_range(30, 100);
      resp_u    = ($urandom_range(0, 3) != 0);
      resp_p    = ($urandom_range(0, 3) != 0);
      bias_voltage_i = 16'($urandom);
      cali_uop_i     = 16'($urandom);
      run(200);
    end

    // reset while the DAC write is pending
    stray = 0; resp_u = 1; resp_p = 1; rdy_pct = 0;
    loop_en_i = 1'b1; cali_en_i = 1'b0; period_i = 32'd63;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      cycle();
      if (m_stage == 3) got = 1;
    end
    chk("reach_dac_wr", got, 1);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("rst_outputs", {dac_wr_o, ufeed_rd_o, pid_start_o, state_o, mode_o, dac_data_o}, '0);
    chk("rst_counters", {timeout_cnt_o, overrun_cnt_o}, '0);
    rdy_pct = 100;
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fbc_loop_sequencer.md
Name: fbc_loop_sequencer

Overview:
- Schedules one FBC motor-control iteration per configurable period: Ufeed read, PID compute start, PID result capture, DAC write.
- Selects the DAC source each period: calibration setpoint, bias voltage during settle, or closed-loop PID output.
- Sits between host config registers and the PID datapath / motor DAC driver.
- Replaces the fixed-frequency trigger counter; adds timeout and overrun accounting.

Parameters:
- TIMEOUT_CYC, 64: max cycles in any WAIT state before abort.
- SETTLE_TRIG, 16: bias-only periods after loop enable before closing the loop.
- MIN_PERIOD, 63: period_i values below this are clamped to it.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- loop_en_i  in  1  request closed-loop operation.
- cali_en_i  in  1  calibration mode; has priority over loop_en_i.
- period_i  in  32  trigger period in clk cycles, minus 1.
- bias_voltage_i  in  16  bias DAC code.
- cali_uop_i  in  16  calibration DAC code.
- ufeed_rd_o  out  1  one-cycle Ufeed read request.
- ufeed_vld_i  in  1  Ufeed sample latched by datapath.
- pid_start_o  out  1  one-cycle PID compute start.
- pid_done_i  in  1  PID result valid pulse.
- pid_data_i  in  16  PID DAC code; already saturated and biased.
- dac_wr_o  out  1  DAC write valid.
- dac_data_o  out  16  DAC write data.
- dac_ready_i  in  1  DAC accepts when dac_wr_o && dac_ready_i.
- state_o  out  3  current FSM state.
- mode_o  out  2  0 OFF, 1 BIAS, 2 CALI, 3 CLOSED.
- timeout_cnt_o  out  16  saturating timeout count.
- overrun_cnt_o  out  16  saturating dropped-tick count.

Behaviour:
- Reset: all outputs 0; state IDLE; mode OFF; period counter, settle counter and stat counters cleared.
- Tick generation:
  - cnt increments every cycle.
  - When cnt >= max(period_i, MIN_PERIOD): cnt returns to 0 and a registered tick pulses for one cycle.
  - A change to period_i takes effect at the next compare.
- Mode, evaluated every cycle:
  - cali_en_i=1 gives CALI.
  - Otherwise loop_en_i=1 with settle_cnt < SETTLE_TRIG gives BIAS.
  - Otherwise loop_en_i=1 gives CLOSED.
  - Otherwise OFF.
  - settle_cnt increments on each tick accepted in BIAS and saturates at SETTLE_TRIG.
  - settle_cnt clears whenever loop_en_i=0 or cali_en_i=1.
- FSM states: IDLE=0, WAIT_UFEED=1, WAIT_PID=2, DAC_WR=3.
- IDLE with tick:
  - OFF: no action.
  - CALI or BIAS: next cycle enter DAC_WR; dac_data_o = cali_uop_i or bias_voltage_i.
  - CLOSED: next cycle enter WAIT_UFEED with ufeed_rd_o=1 for exactly that cycle.
- WAIT_UFEED: on ufeed_vld_i, next cycle enter WAIT_PID with pid_start_o=1 for one cycle.
- WAIT_PID: on pid_done_i, capture pid_data_i into dac_data_o; next cycle enter DAC_WR.
- DAC_WR:
  - dac_wr_o=1 and dac_data_o held stable until dac_ready_i.
  - On acceptance, next cycle IDLE with dac_wr_o=0.
  - No timeout; the DAC handshake always completes.
- Timeout:
  - A wait counter clears on entering WAIT_UFEED or WAIT_PID.
  - When it reaches TIMEOUT_CYC: timeout_cnt++, return to IDLE, no DAC write.
  - An event arriving in the same cycle as the timeout wins; no timeout is counted.
- Overrun: a tick while state != IDLE does overrun_cnt++ and is dropped. Iterations are never queued.
- Abort: if mode leaves CLOSED while in WAIT_UFEED or WAIT_PID, return to IDLE next cycle without counting. DAC_WR is never aborted.
- Counters saturate at 16'hFFFF and clear only on reset.
- Stray ufeed_vld_i or pid_done_i outside its wait state is ignored.
- Reset mid-handshake drops dac_wr_o on the next edge.

Decomposition:
- Package fbc_seq_pkg:
  - state encodings (IDLE/WAIT_UFEED/WAIT_PID/DAC_WR);
  - mode encodings (OFF/BIAS/CALI/CLOSED);
  - MIN_PERIOD default;
  - 16-bit counter saturation constant.
- Sub-module fbc_period_tick (period counter with clamp, registered tick output).
- FSM, settle counter and stats stay in the top module.

Test Plan:
1. period_i=99, loop_en_i=1, SETTLE_TRIG=16, dac_ready_i=1 -> 16 DAC writes of bias_voltage_i 100 cycles apart. From the 17th tick: ufeed_rd_o 1 cycle after tick; pid_done_i with pid_data_i=16'h1234 yields dac_wr_o with 16'h1234 one cycle later.
2. cali_en_i=1 and loop_en_i=1, cali_uop_i=16'h8000 -> every tick writes 16'h8000. No ufeed_rd_o or pid_start_o. settle_cnt stays 0.
3. CLOSED, pid_done_i never asserted -> return to IDLE 64 cycles after pid_start_o; timeout_cnt_o=1; no dac_wr_o.
4. CLOSED, dac_ready_i held low for 200 cycles with period_i=99 -> dac_data_o stable throughout; overrun_cnt_o=2 when ready finally rises; single write accepted.
5. period_i=10 -> ticks every 64 cycles (clamped).
6. loop_en_i dropped during WAIT_UFEED -> IDLE next cycle; timeout_cnt_o unchanged. Re-enable restarts 16 bias periods.
7. rst_i asserted during DAC_WR -> all outputs 0 next cycle; counters 0.
